// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Reset sequencer sitting directly downstream of the system PLL. It runs on
//   the free-running reference clock, pulses the PLL reset, and waits for a
//   lock indication. It then waits for the lock to stay stable before it
//   releases the design-wide reset. If lock never arrives, it retries the PLL
//   reset. If lock is lost while running, it re-asserts system reset and
//   re-initialises the PLL.
//
// Ports
//   clk           in   reference clock (same net as PLL refclk, never gated)
//   rst_n         in   asynchronous active-low reset
//   pll_locked_i  in   PLL lock indicator, asynchronous to clk
//   pll_rst_o     out  active-high PLL reset
//   sys_rst_n_o   out  active-low system reset (async assert, sync deassert)
//   ready_o       out  high while the sequencer is in RUN
//   retry_cnt_o   out  saturating count of lock timeouts since rst_n
//   relock_cnt_o  out  saturating count of lock losses in RUN since rst_n

module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic [7:0] retry_cnt_o,
  output logic [7:0] relock_cnt_o
);

  // The shared down-counter is sized for the largest load value.
  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ?
                                   MAX_AB : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   retry_inc;
  logic                   relock_inc;

  // Lock synchronizer: pll_locked_i is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // State and shared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PLL_RST;
      cnt_q   <= RST_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter is reloaded on every state entry, so
  // each state's dwell time is measured from its own entry edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? (cnt_q - 1'b1) : cnt_q;
    retry_inc  = 1'b0;
    relock_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end
      end
      S_WAIT_LOCK: begin
        // Lock wins over a timeout that expires in the same cycle.
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d   = S_PLL_RST;
          cnt_d     = RST_LOAD;
          retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        // A glitch drops back to WAIT_LOCK with a fresh timeout, which
        // restarts the whole stability window on the next lock.
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d    = S_PLL_RST;
          cnt_d      = RST_LOAD;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // Outputs are registered from the next state, so they change on the very
  // edge that enters the corresponding state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_o   <= 1'b1;
      sys_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      pll_rst_o   <= (state_d == S_PLL_RST);
      sys_rst_n_o <= (state_d == S_RUN);
      ready_o     <= (state_d == S_RUN);
    end
  end

  // Saturating event counters; cleared only by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_o  <= '0;
      relock_cnt_o <= '0;
    end else begin
      if (retry_inc && (retry_cnt_o != 8'hFF)) begin
        retry_cnt_o <= retry_cnt_o + 8'd1;
      end
      if (relock_inc && (relock_cnt_o != 8'hFF)) begin
        relock_cnt_o <= relock_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//   Directed bench for pll_reset_seq with small parameters
//   (SYNC=2, PLL_RST=4, TIMEOUT=32, STABLE=8). The table covers power-up,
//   clean lock, lock loss in RUN and relock. Hand-written sequences cover
//   the timeout retry and saturation, a glitch in STABLE, and async reset.

module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       pll_rst_o;
  logic       sys_rst_n_o;
  logic       ready_o;
  logic [7:0] retry_cnt_o;
  logic [7:0] relock_cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  pll_reset_seq #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked_i(pll_locked_i),
    .pll_rst_o   (pll_rst_o),
    .sys_rst_n_o (sys_rst_n_o),
    .ready_o     (ready_o),
    .retry_cnt_o (retry_cnt_o),
    .relock_cnt_o(relock_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       lk;
    logic       pll;
    logic       sys;
    logic       rdy;
    logic [7:0] retry;
    logic [7:0] relock;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int reps, input logic r, input logic lk,
                     input logic pll, input logic sys, input logic rdy,
                     input logic [7:0] retry, input logic [7:0] relock);
    for (int i = 0; i < reps; i++) begin
      tbl.push_back('{r, lk, pll, sys, rdy, retry, relock});
    end
  endtask

  function automatic logic [18:0] outs();
    return {pll_rst_o, sys_rst_n_o, ready_o, retry_cnt_o, relock_cnt_o};
  endfunction

  task automatic check(input string name, input logic [18:0] act,
                       input logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pll=%b sys=%b rdy=%b retry=%0d relock=%0d, expected pll=%b sys=%b rdy=%b retry=%0d relock=%0d",
               name, act[18], act[17], act[16], act[15:8], act[7:0],
               exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  // Drive lock, advance one edge, sample 1 time unit after it.
  task automatic step(input logic lk);
    pll_locked_i = lk;
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between edges; the next edge is edge 1.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic ok;
    logic exp_pll;
    logic [7:0] exp_retry;

    rst_n        = 1'b1;
    pll_locked_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});

    // Scenarios 1, 2 and 5 as one continuous vector table.
    add(2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0); // clocks under reset
    add(3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0); // edges 1-3
    add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0); // edge 4: WAIT_LOCK
    add(10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0); // E=5 .. E+9
    add(2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0); // E+10: RUN
    add(2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0); // lock dropped
    add(4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1); // two edges later
    add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1); // WAIT_LOCK
    add(10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1); // relock E=24
    add(2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd1); // RUN at E+10

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      step(tbl[i].lk);
      check($sformatf("table[%0d]", i), outs(),
            {tbl[i].pll, tbl[i].sys, tbl[i].rdy, tbl[i].retry, tbl[i].relock});
    end

    // Glitch in STABLE: high edges 5-9, low at 10, high from 11.
    pulse_reset();
    for (int n = 1; n <= 22; n++) begin
      logic lk;
      lk = ((n >= 5) && (n <= 9)) || (n >= 11);
      step(lk);
      check($sformatf("glitch_e%0d", n), outs(),
            {(n < 4), (n >= 21), (n >= 21), 8'd0, 8'd0});
    end

    // Timeout retries: PLL_RST dwell 4, WAIT_LOCK dwell 32 -> period 36.
    pulse_reset();
    for (int n = 1; n <= 36 * 300 + 40; n++) begin
      step(1'b0);
      exp_pll   = (n < 4) ? 1'b1 : (((n - 4) % 36) >= 32);
      exp_retry = ((n / 36) > 255) ? 8'd255 : 8'((n / 36));
      check($sformatf("timeout_e%0d", n), outs(),
            {exp_pll, 1'b0, 1'b0, exp_retry, 8'd0});
    end

    // Reach RUN, lose lock, then sit mid-STABLE before the async reset.
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step(1'b1);
      if (ready_o) ok = 1'b1;
    end
    check("reach_run", {ok, 18'd0}, {1'b1, 18'd0});
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(1'b0);
      if (pll_rst_o) ok = 1'b1;
    end
    check("loss_pll_rst", {ok, 18'd0}, {1'b1, 18'd0});
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step(1'b0);
      if (!pll_rst_o) ok = 1'b1;
    end
    check("loss_pll_rst_end", {ok, 18'd0}, {1'b1, 18'd0});
    for (int i = 0; i < 5; i++) step(1'b1);
    check("mid_stable", outs(), {1'b0, 1'b0, 1'b0, 8'd255, 8'd1});

    // Async reset with no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), {1'b1, 1'b0, 1'b0, 8'd0, 8'd0});
    pll_locked_i = 1'b0;
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step(1'b0);
      check($sformatf("restart_e%0d", n), outs(),
            {(n < 4), 1'b0, 1'b0, 8'd0, 8'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
